// File: rtl/pc_sequencer.sv
// Next-PC stage: owns PC, EPC/Cause trap state and the retire counter.
// Commits one instruction per cycle when pc_valid & imem_ready.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ready,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic        Exception,
  input  logic        eret,
  input  logic [25:0] Inst_G,
  input  logic [31:0] Sign_Extended,
  output logic [31:0] PC,
  output logic [31:0] PC_4,
  output logic        pc_valid,
  output logic [31:0] EPC,
  output logic [1:0]  Cause,
  output logic        in_handler,
  output logic        halted,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    TRAP,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] jmp_target;
  logic [31:0] br_target;
  logic [31:0] target;
  logic        fault;
  logic [1:0]  trap_cause;

  assign PC_4       = PC + 32'd4;
  assign jmp_target = {PC_4[31:28], Inst_G, 2'b00};
  assign br_target  = PC_4 + {Sign_Extended[29:0], 2'b00};

  always_comb begin
    target = PC_4;
    if (eret)
      target = EPC;
    else if (Jump)
      target = jmp_target;
    else if (Branch & Zero)
      target = br_target;
  end

  // A misaligned target can only come from a corrupt EPC via eret.
  assign fault      = Exception | (target[1:0] != 2'b00);
  assign trap_cause = Exception ? 2'd1 : 2'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      PC         <= RESET_PC;
      EPC        <= 32'd0;
      Cause      <= 2'd0;
      retired    <= 32'd0;
      in_handler <= 1'b0;
      halted     <= 1'b0;
      pc_valid   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= FETCH;
          pc_valid <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            retired <= retired + 32'd1;
            if (fault) begin
              pc_valid <= 1'b0;
              if (in_handler) begin
                halted <= 1'b1;
                state  <= HALT;
              end else begin
                EPC        <= PC;
                Cause      <= trap_cause;
                in_handler <= 1'b1;
                PC         <= EXC_VECTOR;
                state      <= TRAP;
              end
            end else begin
              PC <= target;
              if (eret)
                in_handler <= 1'b0;
            end
          end
        end
        TRAP: begin
          state    <= FETCH;
          pc_valid <= 1'b1;
        end
        HALT: begin
          pc_valid <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, branch/jump,
// trap entry/return, double-fault halt and asynchronous reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ready;
  logic        Branch;
  logic        Zero;
  logic        Jump;
  logic        Exception;
  logic        eret;
  logic [25:0] Inst_G;
  logic [31:0] Sign_Extended;
  logic [31:0] PC;
  logic [31:0] PC_4;
  logic        pc_valid;
  logic [31:0] EPC;
  logic [1:0]  Cause;
  logic        in_handler;
  logic        halted;
  logic [31:0] retired;

  int tests = 0;
  int fails = 0;

  pc_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_ready(imem_ready),
    .Branch(Branch),
    .Zero(Zero),
    .Jump(Jump),
    .Exception(Exception),
    .eret(eret),
    .Inst_G(Inst_G),
    .Sign_Extended(Sign_Extended),
    .PC(PC),
    .PC_4(PC_4),
    .pc_valid(pc_valid),
    .EPC(EPC),
    .Cause(Cause),
    .in_handler(in_handler),
    .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ctl_clear();
    Branch        = 1'b0;
    Zero          = 1'b0;
    Jump          = 1'b0;
    Exception     = 1'b0;
    eret          = 1'b0;
    Inst_G        = 26'd0;
    Sign_Extended = 32'd0;
  endtask

  task automatic do_reset();
    ctl_clear();
    imem_ready = 1'b0;
    rst_n      = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    ctl_clear();
    imem_ready = 1'b0;
    rst_n      = 1'b0;
    #3;
    chk("rst_pc", PC, 32'h0);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cause", {30'd0, Cause}, 32'd0);

    // sequential fetch
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("fetch_valid", {31'd0, pc_valid}, 32'd1);
    chk("fetch_pc0", PC, 32'h0);
    chk("pc4", PC_4, 32'h4);
    imem_ready = 1'b1;
    tick();
    chk("seq_pc4", PC, 32'h4);
    tick();
    chk("seq_pc8", PC, 32'h8);
    tick();
    chk("seq_pcc", PC, 32'hC);
    chk("seq_retired", retired, 32'd3);

    // branches
    Jump = 1'b1; Inst_G = 26'h10;
    tick();
    chk("jmp_40", PC, 32'h40);
    ctl_clear();
    Branch = 1'b1; Zero = 1'b1; Sign_Extended = 32'hFFFF_FFFE;
    tick();
    chk("br_taken", PC, 32'h3C);
    ctl_clear();
    Jump = 1'b1; Inst_G = 26'h10;
    tick();
    ctl_clear();
    Branch = 1'b1; Zero = 1'b0; Sign_Extended = 32'hFFFF_FFFE;
    tick();
    chk("br_not_taken", PC, 32'h44);
    ctl_clear();
    Branch = 1'b1; Zero = 1'b1; Sign_Extended = 32'h03FF_FFF2;
    tick();
    chk("br_far", PC, 32'h1000_0010);

    // jumps keep the upper nibble; jump beats a taken branch
    ctl_clear();
    Jump = 1'b1; Inst_G = 26'h100;
    tick();
    chk("jmp_hi", PC, 32'h1000_0400);
    Branch = 1'b1; Zero = 1'b1; Sign_Extended = 32'h1;
    tick();
    chk("jmp_prio", PC, 32'h1000_0400);
    chk("retired_10", retired, 32'd10);

    // trap entry, ignored inputs in the bubble, eret
    do_reset();
    imem_ready = 1'b1;
    Jump = 1'b1; Inst_G = 26'h8;
    tick();
    chk("pc_20", PC, 32'h20);
    ctl_clear();
    Exception = 1'b1;
    tick();
    chk("trap_epc", EPC, 32'h20);
    chk("trap_cause", {30'd0, Cause}, 32'd1);
    chk("trap_pc", PC, 32'h180);
    chk("trap_valid", {31'd0, pc_valid}, 32'd0);
    chk("trap_inh", {31'd0, in_handler}, 32'd1);
    ctl_clear();
    eret = 1'b1;
    tick();
    chk("bubble_pc", PC, 32'h180);
    chk("bubble_inh", {31'd0, in_handler}, 32'd1);
    chk("bubble_valid", {31'd0, pc_valid}, 32'd1);
    tick();
    chk("eret_pc", PC, 32'h20);
    chk("eret_inh", {31'd0, in_handler}, 32'd0);
    chk("eret_cause", {30'd0, Cause}, 32'd1);
    chk("eret_retired", retired, 32'd3);

    // double fault
    do_reset();
    imem_ready = 1'b1;
    Jump = 1'b1; Inst_G = 26'h8;
    tick();
    ctl_clear();
    Exception = 1'b1;
    tick();
    Exception = 1'b0;
    tick();
    Exception = 1'b1;
    tick();
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, pc_valid}, 32'd0);
    chk("halt_pc", PC, 32'h180);
    chk("halt_retired", retired, 32'd3);
    Exception = 1'b0;
    eret = 1'b1;
    repeat (10) tick();
    chk("halt_pc_10", PC, 32'h180);
    chk("halt_flag_10", {31'd0, halted}, 32'd1);
    chk("halt_valid_10", {31'd0, pc_valid}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("halt_rst_pc", PC, 32'h0);
    chk("halt_rst_flag", {31'd0, halted}, 32'd0);

    // stall then asynchronous reset mid-stall
    do_reset();
    imem_ready = 1'b1;
    tick();
    tick();
    chk("pre_stall_pc", PC, 32'h8);
    imem_ready = 1'b0;
    Jump = 1'b1; Inst_G = 26'h10;
    repeat (3) tick();
    chk("stall_pc", PC, 32'h8);
    chk("stall_retired", retired, 32'd2);
    chk("stall_valid", {31'd0, pc_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc", PC, 32'h0);
    chk("async_retired", retired, 32'd0);
    chk("async_valid", {31'd0, pc_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
